morse_sequencer: RTL

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

---
 rtl/morse_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - Morse letter keyer; MORSE_SEQ_WORD_GAP_EN turns code_len=0 into a word space
module morse_sequencer #(
    parameter int UNIT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic [4:0] code_bits,
    input  logic [2:0] code_len,
    input  logic       abort,
    output logic       key,
    output logic       busy,
    output logic       done
);

`ifdef MORSE_SEQ_WORD_GAP_EN
    localparam int SPAN = 7 * UNIT_CYCLES;
`else
    localparam int SPAN = 3 * UNIT_CYCLES;
`endif
    localparam int CW = $clog2(SPAN);

    localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_SEQ_WORD_GAP_EN
    localparam logic [CW-1:0] WORD_LAST = CW'(7 * UNIT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_GAP,
`ifdef MORSE_SEQ_WORD_GAP_EN
        S_WGAP,
`endif
        S_LGAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bits_q, bits_d;
    logic [2:0]    rem_q, rem_d;
    logic          done_q, done_d;
    logic [2:0]    len_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bits_d  = bits_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        len_eff = (code_len > 3'd5) ? 3'd5 : code_len;

        case (state_q)
            S_IDLE: begin
                if (code_valid) begin
                    bits_d = code_bits;
                    rem_d  = len_eff;
                    if (len_eff != 3'd0) begin
                        state_d = S_MARK;
                    end else begin
`ifdef MORSE_SEQ_WORD_GAP_EN
                        state_d = S_WGAP;
`else
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            // bits_q is shifted so bit0 is always the element being keyed
            S_MARK: begin
                if (cnt_q == (bits_q[0] ? DASH_LAST : DOT_LAST)) begin
                    bits_d  = bits_q >> 1;
                    rem_d   = rem_q - 3'd1;
                    state_d = (rem_q == 3'd1) ? S_LGAP : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == DOT_LAST) state_d = S_MARK;
            end
            S_LGAP: begin
                if (cnt_q == DASH_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef MORSE_SEQ_WORD_GAP_EN
            S_WGAP: begin
                if (cnt_q == WORD_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // abort overrides any expiry decided above
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    end

    assign key        = (state_q == S_MARK);
    assign busy       = (state_q != S_IDLE);
    assign code_ready = (state_q == S_IDLE);
    assign done       = done_q;

endmodule
